// File: rtl/keypad_lock_sequencer.sv
// Sequencer between the 8-digit keypad checker and the door actuator:
// arms the checker, grants timed unlock on success, enforces lockout after repeated failures.
module keypad_lock_sequencer #(
   parameter int MAX_FAILS      = 3,
   parameter int UNLOCK_CYCLES  = 500,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int TIMER_W        = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       door_status_correct,
   input  logic       door_status_incorrect,
   input  logic       cancel,
   input  logic       admin_clear,
   output logic       keypad_reset,
   output logic       unlock,
   output logic       lockout,
   output logic [3:0] fail_count,
   output logic [7:0] lockout_events
);

   // state      | meaning
   // ST_ARM     | checker held in reset for one cycle before accepting digits
   // ST_LISTEN  | checker running, waiting for correct/incorrect/cancel
   // ST_UNLOCK  | door enabled for UNLOCK_CYCLES, checker held in reset
   // ST_LOCKOUT | keypad ignored for LOCKOUT_CYCLES or until admin_clear
   typedef enum logic [1:0] {ST_ARM, ST_LISTEN, ST_UNLOCK, ST_LOCKOUT} state_t;

   localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
   localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
   localparam logic [4:0]         MAX_FAILS_W  = 5'(MAX_FAILS);

   state_t               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [3:0]           fail_count_q, fail_count_d;
   logic [7:0]           lockout_events_q, lockout_events_d;
   logic                 keypad_reset_q, keypad_reset_d;
   logic                 unlock_q, unlock_d;
   logic                 lockout_q, lockout_d;
   logic                 last_fail;

   assign last_fail = (({1'b0, fail_count_q} + 5'd1) == MAX_FAILS_W);

   always_comb begin
      state_d          = state_q;
      timer_d          = timer_q;
      fail_count_d     = fail_count_q;
      lockout_events_d = lockout_events_q;
      case (state_q)
         ST_ARM: state_d = ST_LISTEN;
         ST_LISTEN: begin
            if (door_status_correct) begin
               state_d      = ST_UNLOCK;
               timer_d      = UNLOCK_LOAD;
               fail_count_d = 4'd0;
            end else if (door_status_incorrect) begin
               if (last_fail) begin
                  state_d      = ST_LOCKOUT;
                  timer_d      = LOCKOUT_LOAD;
                  fail_count_d = 4'd0;
                  if (lockout_events_q != 8'hFF) lockout_events_d = lockout_events_q + 8'd1;
               end else begin
                  state_d      = ST_ARM;
                  fail_count_d = fail_count_q + 4'd1;
               end
            end else if (cancel) begin
               state_d = ST_ARM;
            end
         end
         ST_UNLOCK: begin
            if (timer_q == '0) state_d = ST_ARM;
            else               timer_d = timer_q - 1'b1;
         end
         ST_LOCKOUT: begin
            if (timer_q == '0 || admin_clear) state_d = ST_ARM;
            else                              timer_d = timer_q - 1'b1;
         end
         default: state_d = ST_ARM;
      endcase
      // Outputs are registered alongside the state so they carry no input paths.
      keypad_reset_d = (state_d != ST_LISTEN);
      unlock_d       = (state_d == ST_UNLOCK);
      lockout_d      = (state_d == ST_LOCKOUT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= ST_ARM;
         timer_q          <= '0;
         fail_count_q     <= 4'd0;
         lockout_events_q <= 8'd0;
         keypad_reset_q   <= 1'b1;
         unlock_q         <= 1'b0;
         lockout_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         timer_q          <= timer_d;
         fail_count_q     <= fail_count_d;
         lockout_events_q <= lockout_events_d;
         keypad_reset_q   <= keypad_reset_d;
         unlock_q         <= unlock_d;
         lockout_q        <= lockout_d;
      end
   end

   assign keypad_reset   = keypad_reset_q;
   assign unlock         = unlock_q;
   assign lockout        = lockout_q;
   assign fail_count     = fail_count_q;
   assign lockout_events = lockout_events_q;

endmodule

// File: tb/tb_keypad_lock_sequencer.sv
// Bench for keypad_lock_sequencer: directed scenarios plus random traffic against a
// window-countdown reference model.
module tb_keypad_lock_sequencer;

   localparam int MAX_FAILS      = 3;
   localparam int UNLOCK_CYCLES  = 500;
   localparam int LOCKOUT_CYCLES = 1000;

   localparam int P_ARM = 0, P_LISTEN = 1, P_OPEN = 2, P_LOCKED = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       door_status_correct = 1'b0;
   logic       door_status_incorrect = 1'b0;
   logic       cancel = 1'b0;
   logic       admin_clear = 1'b0;
   logic       keypad_reset, unlock, lockout;
   logic [3:0] fail_count;
   logic [7:0] lockout_events;

   int errors = 0;
   int checks = 0;

   int m_phase, m_left, m_fails, m_events;

   keypad_lock_sequencer #(
      .MAX_FAILS(MAX_FAILS), .UNLOCK_CYCLES(UNLOCK_CYCLES),
      .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .TIMER_W(16)
   ) dut (
      .clk(clk), .reset(reset),
      .door_status_correct(door_status_correct), .door_status_incorrect(door_status_incorrect),
      .cancel(cancel), .admin_clear(admin_clear),
      .keypad_reset(keypad_reset), .unlock(unlock), .lockout(lockout),
      .fail_count(fail_count), .lockout_events(lockout_events)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = P_ARM; m_left = 0; m_fails = 0; m_events = 0;
   endtask

   // One cycle of the lock rules; m_left counts the window cycles still to be served.
   task automatic model_step(input logic c, input logic i, input logic cn, input logic ad);
      case (m_phase)
         P_ARM: m_phase = P_LISTEN;
         P_LISTEN: begin
            if (c) begin
               m_phase = P_OPEN; m_left = UNLOCK_CYCLES; m_fails = 0;
            end else if (i) begin
               if (m_fails + 1 == MAX_FAILS) begin
                  m_phase = P_LOCKED; m_left = LOCKOUT_CYCLES; m_fails = 0;
                  m_events = (m_events < 255) ? m_events + 1 : 255;
               end else begin
                  m_fails++; m_phase = P_ARM;
               end
            end else if (cn) m_phase = P_ARM;
         end
         P_OPEN: begin
            m_left--;
            if (m_left == 0) m_phase = P_ARM;
         end
         default: begin
            m_left--;
            if (m_left == 0 || ad) m_phase = P_ARM;
         end
      endcase
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".keypad_reset"}, {7'd0, keypad_reset}, {7'd0, m_phase != P_LISTEN});
      chk({tag, ".unlock"},       {7'd0, unlock},       {7'd0, m_phase == P_OPEN});
      chk({tag, ".lockout"},      {7'd0, lockout},      {7'd0, m_phase == P_LOCKED});
      chk({tag, ".fail_count"},   {4'd0, fail_count},   8'(m_fails));
      chk({tag, ".lockout_events"}, lockout_events,     8'(m_events));
   endtask

   task automatic step(input string tag, input logic c, input logic i, input logic cn, input logic ad);
      door_status_correct = c; door_status_incorrect = i; cancel = cn; admin_clear = ad;
      @(posedge clk);
      if (!reset) model_reset();
      else        model_step(c, i, cn, ad);
      #1;
      check_outputs(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int k = 0; k < n; k++) step(tag, 0, 0, 0, 0);
   endtask

   task automatic wait_listen(input string tag);
      int n;
      n = 0;
      while (m_phase != P_LISTEN && n < 2000) begin
         step(tag, 0, 0, 0, 0);
         n++;
      end
      chk({tag, ".listen_timeout"}, 8'(n < 2000), 8'd1);
   endtask

   task automatic fail_once(input string tag);
      wait_listen(tag);
      step(tag, 0, 1, 0, 0);
   endtask

   int hi_cnt;

   initial begin
      model_reset();
      #12;
      check_outputs("in_reset");
      reset = 1'b1;
      #1;
      check_outputs("after_release");

      // correct pulse at cycle 10 -> unlock exactly UNLOCK_CYCLES cycles
      idle("pre_correct", 9);
      step("correct", 1, 0, 0, 0);
      hi_cnt = (unlock === 1'b1) ? 1 : 0;
      for (int k = 0; k < UNLOCK_CYCLES + 20; k++) begin
         step("unlock_win", 0, 0, 0, 0);
         if (unlock === 1'b1) hi_cnt++;
      end
      chk("unlock_len_lo", 8'(hi_cnt), 8'(UNLOCK_CYCLES));
      chk("unlock_len_hi", 8'(hi_cnt >> 8), 8'(UNLOCK_CYCLES >> 8));

      // three failures -> lockout for exactly LOCKOUT_CYCLES
      fail_once("fail1");
      fail_once("fail2");
      fail_once("fail3");
      hi_cnt = (lockout === 1'b1) ? 1 : 0;
      for (int k = 0; k < LOCKOUT_CYCLES + 20; k++) begin
         step("lock_win", 0, 0, 0, 0);
         if (lockout === 1'b1) hi_cnt++;
      end
      chk("lock_len_lo", 8'(hi_cnt), 8'(LOCKOUT_CYCLES));
      chk("lock_len_hi", 8'(hi_cnt >> 8), 8'(LOCKOUT_CYCLES >> 8));

      // two failures, then success clears count; a single failure after does not lock
      fail_once("f2a");
      fail_once("f2b");
      wait_listen("pre_ok");
      step("ok_after_fails", 1, 0, 0, 0);
      fail_once("single_fail");
      idle("after_single", 4);

      // lockout ignores keypad/cancel, admin_clear ends it early
      fail_once("lk_a");
      fail_once("lk_b");
      step("lk_ign_c", 1, 0, 0, 0);
      step("lk_ign_i", 0, 1, 0, 0);
      step("lk_ign_cn", 0, 0, 1, 0);
      step("lk_ign_all", 1, 1, 1, 0);
      step("lk_admin", 0, 0, 0, 1);
      idle("post_admin", 3);

      // async reset in the middle of unlock
      wait_listen("pre_rst");
      step("rst_correct", 1, 0, 0, 0);
      idle("unlock_run", 199);
      reset = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
      step("rst_hold", 0, 0, 0, 0);
      step("rst_hold", 1, 1, 1, 1);
      reset = 1'b1;
      idle("rst_release", 3);

      // correct beats incorrect; cancel keeps fail count
      wait_listen("pre_both");
      step("both", 1, 1, 0, 0);
      fail_once("cn_f1");
      fail_once("cn_f2");
      wait_listen("pre_cancel");
      step("cancel", 0, 0, 1, 0);
      step("inc_and_cancel", 0, 1, 1, 0);

      // lockout_events saturation, short lockouts via admin_clear
      for (int n = 0; n < 258; n++) begin
         fail_once("sat");
         fail_once("sat");
         fail_once("sat");
         step("sat_admin", 0, 0, 0, 1);
      end

      // random traffic
      for (int k = 0; k < 20000; k++) begin
         step("rand",
              ($urandom_range(0, 99) < 2),
              ($urandom_range(0, 99) < 4),
              ($urandom_range(0, 99) < 6),
              ($urandom_range(0, 999) < 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
